peripheral_uart_rx_deframer: RTL and testbench
==============================================

// Module: peripheral_uart_rx_deframer
// PURPOSE
//  Downstream peer of the APB4 UART transmitter: consumes the serial line driven by tx_o and deframes it.
//  Recovers bytes using mid-bit sampling and buffers them in a small FIFO.
//  Presents the bytes on a valid/ready stream for bench scoreboards and SoC loopback paths.
//  Frame format: 1 start bit, 8 data bits LSB first, optional parity, 1 stop bit.
// PARAMETERS
//  DIV_WIDTH   16  width of the clocks-per-bit divisor input
//  FIFO_DEPTH  4   byte FIFO entries; must be a power of 2, >=2
//  SYNC_DEPTH  2   flops in the rx_i synchroniser (>=2)
// PORTS
//  CLK           in   1          clock; single clock domain
//  RST           in   1          synchronous reset, active-high
//  cfg_div_i     in   DIV_WIDTH  clocks per bit; values <4 are treated as 4
//  cfg_par_en_i  in   1          1 = parity bit present after D7
//  cfg_par_odd_i in   1          1 = odd parity, 0 = even parity
//  rx_i          in   1          serial line; idles high
//  data_o        out  8          FIFO head byte
//  par_err_o     out  1          FIFO head: parity mismatch
//  frm_err_o     out  1          FIFO head: stop bit sampled low
//  valid_o       out  1          FIFO non-empty
//  ready_i       in   1          consumer accepts the head entry when valid_o && ready_i
//  overrun_o     out  1          1-cycle pulse: a frame completed while the FIFO was full
//  busy_o        out  1          FSM not in IDLE
// BEHAVIOUR
//  Reset (RST=1 at a CLK edge):
//   - FSM goes to IDLE; FIFO flushed; divisor/bit counters cleared.
//   - Synchroniser flops preset to 1.
//   - data_o=0, par_err_o=0, frm_err_o=0, valid_o=0, overrun_o=0, busy_o=0.
//   - Reset mid-frame discards the partial byte.
//  Synchroniser: rx_s = rx_i delayed by SYNC_DEPTH cycles. All decisions use rx_s.
//  Divisor: N = max(cfg_div_i,4), latched on start detect and held for the whole frame.
//   Config changes mid-frame take effect on the next frame.
//  FSM states IDLE, START, DATA, PARITY, STOP:
//   - IDLE: on a 1->0 edge of rx_s, latch N and config, clear cnt, go to START.
//   - START: when cnt == N/2-1 (floor), sample rx_s.
//       1 -> false start; return to IDLE with no output.
//       0 -> go to DATA; cnt restarts at 0.
//   - DATA: sample every N cycles (cnt == N-1), shifting in LSB first.
//       After the 8th sample, go to PARITY if par_en, else STOP.
//   - PARITY: sample after N cycles. par_err = (^data ^ sample) != odd.
//   - STOP: sample after N cycles. frm_err = ~sample.
//       Push {frm_err, par_err, data}. Return to IDLE on the same edge; no wait for line high.
//       If the stop bit was low, IDLE re-arms on the next 1->0 edge only (line must return high first).
//  Sampling lands at mid-bit: each sample is N/2 + k*N cycles after the start edge at rx_s.
//  FIFO:
//   - Push happens in the STOP sample cycle.
//   - Full at push: the byte is dropped, FIFO contents are unchanged, overrun_o pulses 1 cycle.
//   - Simultaneous push and pop when full: the pop frees a slot, so the push succeeds with no overrun.
//   - Empty: valid_o=0; data_o and the error outputs hold their last value.
//   - Latency: the byte is visible on data_o/valid_o the cycle after the STOP sample edge.
//   - Pointers wrap modulo FIFO_DEPTH; an extra bit distinguishes full from empty.
//  Parity and framing errors never block the push; they travel with the byte.
// TESTING
//  T1 N=16, no parity, send 0xA5 -> valid_o after ~9.5*16 cycles; data_o=0xA5, errors 0.
//  T2 N=16, par_en=1, even parity, send 0x03 with parity bit 1 -> data_o=0x03, par_err_o=1.
//     Then odd parity, same frame -> par_err_o=0.
//  T3 N=8, stop bit driven 0, send 0x7E -> data_o=0x7E, frm_err_o=1.
//     A following 0x11 after line high -> 0x11, no errors.
//  T4 rx_i low for 3 cycles at N=16 -> no output, busy_o drops after the half-bit check, FIFO empty.
//  T5 ready_i=0, send 0x01..0x05 at N=8 -> 4 entries 0x01..0x04 held, 1 overrun pulse.
//     Then ready_i=1 -> drains in order; 0x05 never appears.
//  T6 RST pulsed mid-DATA of 0x55, then send 0xC3 -> only 0xC3 output, valid_o=0 during reset.
//     Also cfg_div_i=2 is treated as N=4.

Source files
------------

// File: rtl/peripheral_uart_rx_deframer.sv
// UART receive deframer: mid-bit sampling of a synchronised serial line,
// optional parity, and a small byte FIFO with a valid/ready output stream.
module peripheral_uart_rx_deframer #(
  parameter int DIV_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int SYNC_DEPTH = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [DIV_WIDTH-1:0] cfg_div_i,
  input  logic                 cfg_par_en_i,
  input  logic                 cfg_par_odd_i,
  input  logic                 rx_i,
  output logic [7:0]           data_o,
  output logic                 par_err_o,
  output logic                 frm_err_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  state_t                 state_r;
  logic [SYNC_DEPTH-1:0]  sync_r;
  logic                   rx_s;
  logic                   rx_prev_r;
  logic                   start_edge_s;
  logic [DIV_WIDTH-1:0]   div_eff_s;
  logic [DIV_WIDTH-1:0]   div_r;
  logic [DIV_WIDTH-1:0]   cnt_r;
  logic                   half_due_s;
  logic                   bit_due_s;
  logic [2:0]             bit_cnt_r;
  logic [7:0]             shift_r;
  logic                   par_en_r;
  logic                   par_odd_r;
  logic                   par_err_r;
  logic                   busy_r;

  logic                   push_s;
  logic [9:0]             push_data_s;
  logic [9:0]             mem_r [FIFO_DEPTH];
  logic [AW:0]            wr_ptr_r;
  logic [AW:0]            rd_ptr_r;
  logic [AW:0]            wr_nxt_s;
  logic [AW:0]            rd_nxt_s;
  logic                   full_s;
  logic                   pop_s;
  logic                   push_ok_s;
  logic                   next_empty_s;
  logic [9:0]             head_s;
  logic [9:0]             head_r;
  logic                   valid_r;
  logic                   overrun_r;

  assign rx_s         = sync_r[SYNC_DEPTH-1];
  // A low stop bit leaves rx_prev_r low, so re-arming needs the line to go high first.
  assign start_edge_s = rx_prev_r & ~rx_s;
  assign div_eff_s    = (cfg_div_i < DIV_WIDTH'(4)) ? DIV_WIDTH'(4) : cfg_div_i;
  assign half_due_s   = (cnt_r == ((div_r >> 1) - DIV_WIDTH'(1)));
  assign bit_due_s    = (cnt_r == (div_r - DIV_WIDTH'(1)));

  // Input synchroniser and previous-sample register for edge detection.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_r    <= '1;
      rx_prev_r <= 1'b1;
    end else begin
      sync_r    <= {sync_r[SYNC_DEPTH-2:0], rx_i};
      rx_prev_r <= rx_s;
    end
  end

  // Frame FSM: start qualification, data shift, parity and stop sampling.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r   <= ST_IDLE;
      div_r     <= DIV_WIDTH'(4);
      cnt_r     <= '0;
      bit_cnt_r <= 3'd0;
      shift_r   <= 8'h00;
      par_en_r  <= 1'b0;
      par_odd_r <= 1'b0;
      par_err_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_edge_s) begin
            div_r     <= div_eff_s;
            par_en_r  <= cfg_par_en_i;
            par_odd_r <= cfg_par_odd_i;
            par_err_r <= 1'b0;
            cnt_r     <= '0;
            bit_cnt_r <= 3'd0;
            state_r   <= ST_START;
            busy_r    <= 1'b1;
          end
        end
        ST_START: begin
          if (half_due_s) begin
            cnt_r <= '0;
            if (rx_s) begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end else begin
              state_r <= ST_DATA;
            end
          end else begin
            cnt_r <= cnt_r + DIV_WIDTH'(1);
          end
        end
        ST_DATA: begin
          if (bit_due_s) begin
            cnt_r     <= '0;
            shift_r   <= {rx_s, shift_r[7:1]};
            bit_cnt_r <= bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) begin
              state_r <= par_en_r ? ST_PARITY : ST_STOP;
            end
          end else begin
            cnt_r <= cnt_r + DIV_WIDTH'(1);
          end
        end
        ST_PARITY: begin
          if (bit_due_s) begin
            cnt_r     <= '0;
            par_err_r <= (((^shift_r) ^ rx_s) != par_odd_r);
            state_r   <= ST_STOP;
          end else begin
            cnt_r <= cnt_r + DIV_WIDTH'(1);
          end
        end
        ST_STOP: begin
          if (bit_due_s) begin
            cnt_r   <= '0;
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else begin
            cnt_r <= cnt_r + DIV_WIDTH'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  assign push_s       = (state_r == ST_STOP) && bit_due_s;
  assign push_data_s  = {~rx_s, par_err_r, shift_r};
  assign full_s       = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                        (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign pop_s        = valid_r && ready_i;
  assign push_ok_s    = push_s && (!full_s || pop_s);
  assign wr_nxt_s     = wr_ptr_r + (AW+1)'(push_ok_s);
  assign rd_nxt_s     = rd_ptr_r + (AW+1)'(pop_s);
  assign next_empty_s = (wr_nxt_s == rd_nxt_s);

  // Next head entry, forwarding a push that lands in the slot about to become head.
  always_comb begin
    head_s = mem_r[rd_nxt_s[AW-1:0]];
    if (push_ok_s && (rd_nxt_s[AW-1:0] == wr_ptr_r[AW-1:0])) begin
      head_s = push_data_s;
    end else begin
      head_s = mem_r[rd_nxt_s[AW-1:0]];
    end
  end

  // FIFO storage.
  always_ff @(posedge CLK) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= push_data_s;
    end
  end

  // FIFO pointers and registered stream outputs; head holds its value when empty.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      head_r    <= 10'd0;
      valid_r   <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      wr_ptr_r  <= wr_nxt_s;
      rd_ptr_r  <= rd_nxt_s;
      valid_r   <= !next_empty_s;
      overrun_r <= push_s && !push_ok_s;
      if (!next_empty_s) begin
        head_r <= head_s;
      end
    end
  end

  assign data_o    = head_r[7:0];
  assign par_err_o = head_r[8];
  assign frm_err_o = head_r[9];
  assign valid_o   = valid_r;
  assign overrun_o = overrun_r;
  assign busy_o    = busy_r;

endmodule

// File: tb/tb_peripheral_uart_rx_deframer.sv
// Self-checking bench: serial frames are driven bit by bit and the received
// stream is compared with entries predicted from the frame format rules.
module tb_peripheral_uart_rx_deframer;

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] cfg_div_i;
  logic        cfg_par_en_i;
  logic        cfg_par_odd_i;
  logic        rx_i;
  logic [7:0]  data_o;
  logic        par_err_o;
  logic        frm_err_o;
  logic        valid_o;
  logic        ready_i;
  logic        overrun_o;
  logic        busy_o;

  int          pass_cnt = 0;
  int          check_cnt = 0;
  int          ovr_cnt = 0;
  logic [9:0]  got_q[$];
  logic [9:0]  exp_q[$];

  peripheral_uart_rx_deframer #(.DIV_WIDTH(16), .FIFO_DEPTH(4), .SYNC_DEPTH(2)) dut (
    .CLK(CLK), .RST(RST), .cfg_div_i(cfg_div_i), .cfg_par_en_i(cfg_par_en_i),
    .cfg_par_odd_i(cfg_par_odd_i), .rx_i(rx_i), .data_o(data_o), .par_err_o(par_err_o),
    .frm_err_o(frm_err_o), .valid_o(valid_o), .ready_i(ready_i), .overrun_o(overrun_o),
    .busy_o(busy_o)
  );

  always #5 CLK = ~CLK;

  // Capture accepted stream entries and overrun pulses away from the active edge.
  always @(negedge CLK) begin
    if (!RST && valid_o && ready_i) got_q.push_back({frm_err_o, par_err_o, data_o});
    if (overrun_o) ovr_cnt <= ovr_cnt + 1;
  end

  // Expected entry straight from the frame rules: parity counts ones, stop must be high.
  function automatic logic [9:0] model_entry(input logic [7:0] d, input bit pen, input bit odd,
                                             input bit pbit, input bit stop);
    bit perr;
    perr = pen && (((($countones(d) + int'(pbit)) % 2) == 1) != odd);
    return {~stop, perr, d};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_bit(input logic v, input int n);
    rx_i = v;
    repeat (n) tick();
  endtask

  task automatic send_frame(input logic [7:0] d, input int n, input bit pen, input bit pbit,
                            input bit stop, input bit mess);
    drive_bit(1'b0, n);
    if (mess) cfg_div_i = cfg_div_i + 16'd3;
    for (int i = 0; i < 8; i++) drive_bit(d[i], n);
    if (pen) drive_bit(pbit, n);
    drive_bit(stop, n);
    rx_i = 1'b1;
    if (mess) cfg_div_i = cfg_div_i - 16'd3;
  endtask

  task automatic wait_entries();
    for (int c = 0; c < 400 && got_q.size() < exp_q.size(); c++) tick();
  endtask

  task automatic test_reset();
    RST = 1'b1; rx_i = 1'b1; ready_i = 1'b1;
    cfg_div_i = 16'd16; cfg_par_en_i = 1'b0; cfg_par_odd_i = 1'b0;
    repeat (3) tick();
    check_cnt++; if (data_o !== 8'h00) $display("FAIL rst_data got %h exp 00", data_o); else pass_cnt++;
    check_cnt++; if (par_err_o !== 1'b0) $display("FAIL rst_par got %b exp 0", par_err_o); else pass_cnt++;
    check_cnt++; if (frm_err_o !== 1'b0) $display("FAIL rst_frm got %b exp 0", frm_err_o); else pass_cnt++;
    check_cnt++; if (valid_o !== 1'b0) $display("FAIL rst_valid got %b exp 0", valid_o); else pass_cnt++;
    check_cnt++; if (overrun_o !== 1'b0) $display("FAIL rst_ovr got %b exp 0", overrun_o); else pass_cnt++;
    check_cnt++; if (busy_o !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy_o); else pass_cnt++;
    RST = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_basic();
    int lat;
    lat = -1;
    cfg_div_i = 16'd16; cfg_par_en_i = 1'b0;
    exp_q.push_back(model_entry(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1));
    fork
      send_frame(8'hA5, 16, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int c = 0; c < 200 && lat < 0; c++) begin
        tick();
        if (valid_o) lat = c + 1;
      end
    join
    check_cnt++;
    if (lat < 150 || lat > 160) $display("FAIL t1_latency got %0d exp 150..160", lat); else pass_cnt++;
    wait_entries();
    check_cnt++;
    if (got_q.size() != 1) $display("FAIL t1_count got %0d exp 1", got_q.size());
    else begin
      if (got_q[0] !== exp_q[0]) $display("FAIL t1_entry got %h exp %h", got_q[0], exp_q[0]);
      else pass_cnt++;
    end
    got_q.delete(); exp_q.delete();
    repeat (8) tick();
  endtask

  task automatic test_parity();
    cfg_div_i = 16'd16; cfg_par_en_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cfg_par_odd_i = (k == 1);
      exp_q.push_back(model_entry(8'h03, 1'b1, k == 1, 1'b1, 1'b1));
      send_frame(8'h03, 16, 1'b1, 1'b1, 1'b1, 1'b0);
      repeat (16) tick();
    end
    wait_entries();
    check_cnt++;
    if (got_q.size() != 2) $display("FAIL t2_count got %0d exp 2", got_q.size()); else pass_cnt++;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [9:0] g, e;
      g = got_q.pop_front(); e = exp_q.pop_front();
      check_cnt++;
      if (g !== e) $display("FAIL t2_parity got %h exp %h", g, e); else pass_cnt++;
    end
    got_q.delete(); exp_q.delete();
    cfg_par_en_i = 1'b0; cfg_par_odd_i = 1'b0;
  endtask

  task automatic test_framing();
    cfg_div_i = 16'd8;
    exp_q.push_back(model_entry(8'h7E, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(model_entry(8'h11, 1'b0, 1'b0, 1'b0, 1'b1));
    send_frame(8'h7E, 8, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (8) tick();
    send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_entries();
    check_cnt++;
    if (got_q.size() != 2) $display("FAIL t3_count got %0d exp 2", got_q.size()); else pass_cnt++;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [9:0] g, e;
      g = got_q.pop_front(); e = exp_q.pop_front();
      check_cnt++;
      if (g !== e) $display("FAIL t3_framing got %h exp %h", g, e); else pass_cnt++;
    end
    got_q.delete(); exp_q.delete();
    repeat (8) tick();
  endtask

  task automatic test_false_start();
    bit seen;
    seen = 1'b0;
    cfg_div_i = 16'd16;
    rx_i = 1'b0;
    repeat (3) begin tick(); seen |= busy_o; end
    rx_i = 1'b1;
    repeat (20) begin tick(); seen |= busy_o; end
    check_cnt++; if (seen !== 1'b1) $display("FAIL t4_busy_seen got %b exp 1", seen); else pass_cnt++;
    check_cnt++; if (busy_o !== 1'b0) $display("FAIL t4_busy_drop got %b exp 0", busy_o); else pass_cnt++;
    check_cnt++; if (valid_o !== 1'b0) $display("FAIL t4_valid got %b exp 0", valid_o); else pass_cnt++;
  endtask

  task automatic test_overrun();
    int ovr0;
    ovr0 = ovr_cnt;
    cfg_div_i = 16'd8; ready_i = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k <= 4) exp_q.push_back(model_entry(8'(k), 1'b0, 1'b0, 1'b0, 1'b1));
      send_frame(8'(k), 8, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    repeat (4) tick();
    check_cnt++;
    if (ovr_cnt - ovr0 != 1) $display("FAIL t5_overrun got %0d exp 1", ovr_cnt - ovr0); else pass_cnt++;
    check_cnt++;
    if (data_o !== 8'h01 || valid_o !== 1'b1) $display("FAIL t5_head got %h/%b exp 01/1", data_o, valid_o);
    else pass_cnt++;
    ready_i = 1'b1;
    wait_entries();
    repeat (4) tick();
    check_cnt++;
    if (got_q.size() != 4) $display("FAIL t5_count got %0d exp 4", got_q.size()); else pass_cnt++;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [9:0] g, e;
      g = got_q.pop_front(); e = exp_q.pop_front();
      check_cnt++;
      if (g !== e) $display("FAIL t5_drain got %h exp %h", g, e); else pass_cnt++;
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid();
    cfg_div_i = 16'd2; ready_i = 1'b0;
    send_frame(8'h9A, 4, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (2) tick();
    check_cnt++; if (valid_o !== 1'b1) $display("FAIL t6_prefill got %b exp 1", valid_o); else pass_cnt++;
    drive_bit(1'b0, 4);
    drive_bit(1'b1, 4); drive_bit(1'b0, 4); drive_bit(1'b1, 4);
    RST = 1'b1; rx_i = 1'b1;
    tick();
    check_cnt++; if (valid_o !== 1'b0) $display("FAIL t6_valid_rst got %b exp 0", valid_o); else pass_cnt++;
    check_cnt++; if (busy_o !== 1'b0) $display("FAIL t6_busy_rst got %b exp 0", busy_o); else pass_cnt++;
    tick();
    RST = 1'b0; ready_i = 1'b1;
    repeat (4) tick();
    exp_q.push_back(model_entry(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1));
    send_frame(8'hC3, 4, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_entries();
    repeat (4) tick();
    check_cnt++;
    if (got_q.size() != 1) $display("FAIL t6_count got %0d exp 1", got_q.size());
    else begin
      if (got_q[0] !== exp_q[0]) $display("FAIL t6_entry got %h exp %h", got_q[0], exp_q[0]);
      else pass_cnt++;
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    for (int k = 0; k < 12; k++) begin
      logic [7:0] d;
      int cfg, n;
      bit pen, odd, pbit, stop;
      d = 8'($urandom); cfg = $urandom_range(0, 24); n = (cfg < 4) ? 4 : cfg;
      pen = $urandom_range(0, 1); odd = $urandom_range(0, 1);
      pbit = $urandom_range(0, 1); stop = ($urandom_range(0, 3) != 0);
      cfg_div_i = 16'(cfg); cfg_par_en_i = pen; cfg_par_odd_i = odd;
      exp_q.push_back(model_entry(d, pen, odd, pbit, stop));
      send_frame(d, n, pen, pbit, stop, 1'b0);
      repeat (2 * n) tick();
    end
    wait_entries();
    check_cnt++;
    if (got_q.size() != 12) $display("FAIL rnd_count got %0d exp 12", got_q.size()); else pass_cnt++;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [9:0] g, e;
      g = got_q.pop_front(); e = exp_q.pop_front();
      check_cnt++;
      if (g !== e) $display("FAIL rnd_entry got %h exp %h", g, e); else pass_cnt++;
    end
    got_q.delete(); exp_q.delete();
    cfg_par_en_i = 1'b0; cfg_par_odd_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    int n;
    n = $urandom_range(4, 12);
    cfg_div_i = 16'(n); cfg_par_en_i = 1'b1; cfg_par_odd_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      logic [7:0] d;
      bit pbit;
      d = 8'($urandom); pbit = $urandom_range(0, 1);
      exp_q.push_back(model_entry(d, 1'b1, 1'b1, pbit, 1'b1));
      send_frame(d, n, 1'b1, pbit, 1'b1, k == 2);
    end
    wait_entries();
    check_cnt++;
    if (got_q.size() != 6) $display("FAIL b2b_count got %0d exp 6", got_q.size()); else pass_cnt++;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [9:0] g, e;
      g = got_q.pop_front(); e = exp_q.pop_front();
      check_cnt++;
      if (g !== e) $display("FAIL b2b_entry got %h exp %h", g, e); else pass_cnt++;
    end
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_framing();
    test_false_start();
    test_overrun();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
